rv32i_imem_load_controller: RTL and testbench

Sequences program loading into the instruction memory from an external host word stream. Holds the core in reset while it writes words to consecutive word addresses, waits for each write acknowledgement, then releases the core. Sits between the off-core loader and the instruction-memory write port that feeds the fetch stage.

---
 rtl/rv32i_imem_load_controller_pkg.sv | 24 ++
 rtl/rv32i_imem_load_controller_if.sv | 23 ++
 rtl/rv32i_imem_load_controller_checksum.sv | 26 ++
 rtl/rv32i_imem_load_controller.sv | 190 +++++++++++++++++++
 tb/tb_rv32i_imem_load_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_imem_load_controller_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// The checksum feature is enabled by RV32I_IMEM_LOAD_CHECKSUM_EN.
package rv32i_imem_load_pkg;

    localparam int unsigned WORD_STRIDE = 4;
    localparam int unsigned LEN_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_WAIT_ACK,
        ST_CHECK,
        ST_RELEASE,
        ST_ERROR
    } load_state_e;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [LEN_W-1:0] idx);
        return base + (32'(idx) * 32'(WORD_STRIDE));
    endfunction

endpackage

// File: rtl/rv32i_imem_load_controller_if.sv
// Host word stream and instruction-memory write port of the load controller.
// slave = controller side, master = host/memory side.
interface rv32i_imem_load_controller_if;

    logic        i_host_valid;
    logic [31:0] i_host_data;
    logic        o_host_ready;
    logic        o_imem_wr_en;
    logic [31:0] o_imem_wr_addr;
    logic [31:0] o_imem_wr_data;
    logic        i_imem_wr_valid;

    modport slave (
        input  i_host_valid, i_host_data, i_imem_wr_valid,
        output o_host_ready, o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data
    );

    modport master (
        output i_host_valid, i_host_data, i_imem_wr_valid,
        input  o_host_ready, o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data
    );

endinterface

// File: rtl/rv32i_imem_load_controller_checksum.sv
// Running 32-bit additive checksum with clear and add enables.
// Instantiated only when RV32I_IMEM_LOAD_CHECKSUM_EN is defined.
module rv32i_load_checksum (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_add,
    input  logic [31:0] i_data,
    output logic [31:0] o_sum
);

    logic [31:0] r_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/rv32i_imem_load_controller.sv
// Loads a host word stream into instruction memory while holding the core in reset.
// Optional checksum verification: define RV32I_IMEM_LOAD_CHECKSUM_EN.
module rv32i_imem_load_controller
    import rv32i_imem_load_pkg::*;
#(
    parameter int WR_TIMEOUT = 16,
    parameter int BOOT_HOLD  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_load_start,
    input  logic [31:0]                   i_load_base,
    input  logic [15:0]                   i_load_len,
    input  logic [31:0]                   i_load_checksum,
    rv32i_imem_load_controller_if.slave   bus,
    output logic                          o_core_rst,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error
);

    localparam int unsigned TMO_W = $clog2(WR_TIMEOUT + 1);

    load_state_e      r_state, w_state_nxt;
    logic [31:0]      r_base, w_base_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [LEN_W-1:0] r_index, w_index_nxt, w_index_inc;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic             r_wr_en, w_wr_en_nxt;
    logic [31:0]      r_wr_addr, w_wr_addr_nxt;
    logic [31:0]      r_wr_data, w_wr_data_nxt;
    logic             r_core_rst, w_core_rst_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_error, w_error_nxt;
    logic             w_start_take;
    logic             w_ack;
    logic             w_chk_pass;

    assign w_start_take = i_load_start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
    assign w_ack        = (r_state == ST_WAIT_ACK) && bus.i_imem_wr_valid;
    assign w_index_inc  = r_index + LEN_W'(1);

`ifdef RV32I_IMEM_LOAD_CHECKSUM_EN
    logic [31:0] r_exp_sum;
    logic [31:0] w_sum;

    rv32i_load_checksum u_checksum (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_start_take),
        .i_add  (w_ack),
        .i_data (r_wr_data),
        .o_sum  (w_sum)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_exp_sum <= '0;
        end else if (w_start_take) begin
            r_exp_sum <= i_load_checksum;
        end
    end

    assign w_chk_pass = (w_sum == r_exp_sum);
`else
    logic w_unused_checksum;
    assign w_unused_checksum = ^i_load_checksum;
    assign w_chk_pass        = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_len_nxt      = r_len;
        w_index_nxt    = r_index;
        w_tmo_nxt      = r_tmo;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_core_rst_nxt = r_core_rst;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;

        unique case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (i_load_start) begin
                    w_base_nxt     = {i_load_base[31:2], 2'b00};
                    w_len_nxt      = i_load_len;
                    w_index_nxt    = '0;
                    w_tmo_nxt      = '0;
                    w_error_nxt    = 1'b0;
                    w_core_rst_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = (i_load_len == '0) ? ST_CHECK : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (bus.i_host_valid) begin
                    w_wr_data_nxt = bus.i_host_data;
                    w_wr_addr_nxt = word_addr(r_base, r_index);
                    w_wr_en_nxt   = 1'b1;
                    w_state_nxt   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_tmo_nxt   = '0;
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // r_tmo counts prior waiting cycles, so the WR_TIMEOUT-th cycle still accepts an ack.
                if (bus.i_imem_wr_valid) begin
                    w_index_nxt = w_index_inc;
                    w_state_nxt = (w_index_inc == r_len) ? ST_CHECK : ST_ACCEPT;
                end else if (r_tmo == TMO_W'(WR_TIMEOUT - 1)) begin
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (w_chk_pass) begin
                    w_done_nxt     = 1'b1;
                    w_core_rst_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = ST_RELEASE;
                end else begin
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_index    <= '0;
            r_tmo      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_core_rst <= (BOOT_HOLD != 0);
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_base     <= w_base_nxt;
            r_len      <= w_len_nxt;
            r_index    <= w_index_nxt;
            r_tmo      <= w_tmo_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_core_rst <= w_core_rst_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign bus.o_host_ready   = (r_state == ST_ACCEPT);
    assign bus.o_imem_wr_en   = r_wr_en;
    assign bus.o_imem_wr_addr = r_wr_addr;
    assign bus.o_imem_wr_data = r_wr_data;
    assign o_core_rst         = r_core_rst;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_error            = r_error;

endmodule

// File: tb/tb_rv32i_imem_load_controller.sv
// Self-checking bench for rv32i_imem_load_controller: table of loads plus
// hand-written timeout, restart and mid-load reset sequences.
`timescale 1ns/1ps
module tb_rv32i_imem_load_controller;

`ifdef RV32I_IMEM_LOAD_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0]      base;
        int               len;
        logic [3:0][31:0] words;
        int               ack_dly;
        int               gap;
        logic [31:0]      chk;
        bit               chk_given;
        bit               exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [31:0] load_base;
    logic [15:0] load_len;
    logic [31:0] load_chk;
    logic        core_rst, busy, done, error;

    rv32i_imem_load_controller_if bus ();

    rv32i_imem_load_controller #(
        .WR_TIMEOUT (16),
        .BOOT_HOLD  (1)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_load_start    (load_start),
        .i_load_base     (load_base),
        .i_load_len      (load_len),
        .i_load_checksum (load_chk),
        .bus             (bus),
        .o_core_rst      (core_rst),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  last_wr_cyc = 0;
    bit  ack_en = 1'b1;
    int  ack_dly = 0;
    bit  ack_pend = 1'b0;
    int  ack_cnt = 0;
    wr_t exp_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory model and write scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        bus.i_imem_wr_valid = 1'b0;
        if (rst) begin
            ack_pend = 1'b0;
        end else begin
            if (ack_pend) begin
                if (ack_cnt == 0) begin
                    bus.i_imem_wr_valid = 1'b1;
                    ack_pend = 1'b0;
                end else begin
                    ack_cnt--;
                end
            end
            if (bus.o_imem_wr_en === 1'b1) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(bus.o_imem_wr_en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.o_imem_wr_addr, e.addr);
                    check("wr_data", bus.o_imem_wr_data, e.data);
                end
                ack_pend = ack_en;
                ack_cnt  = ack_dly;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic check_reset(input string p);
        check({p, "_host_ready"}, 32'(bus.o_host_ready), 32'd0);
        check({p, "_wr_en"},      32'(bus.o_imem_wr_en), 32'd0);
        check({p, "_wr_addr"},    bus.o_imem_wr_addr, 32'd0);
        check({p, "_wr_data"},    bus.o_imem_wr_data, 32'd0);
        check({p, "_core_rst"},   32'(core_rst), 32'd1);
        check({p, "_busy"},       32'(busy), 32'd0);
        check({p, "_done"},       32'(done), 32'd0);
        check({p, "_error"},      32'(error), 32'd0);
    endtask

    task automatic start_load(input logic [31:0] base, input int len, input logic [31:0] chk);
        load_start = 1'b1;
        load_base  = base;
        load_len   = 16'(len);
        load_chk   = chk;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        int  t;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
        bus.i_host_valid = 1'b1;
        bus.i_host_data  = data;
        t = 0;
        while (!bus.o_host_ready && t < 100) begin
            step();
            t++;
        end
        check("host_ready_wait", 32'(bus.o_host_ready), 32'd1);
        step();
        bus.i_host_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] sum, chk, base_al;
        int lat, wr0, done0;
        string p;
        p = $sformatf("v%0d", idx);
        sum = '0;
        for (int i = 0; i < v.len; i++) sum = sum + v.words[i];
        chk     = v.chk_given ? v.chk : sum;
        base_al = {v.base[31:2], 2'b00};
        ack_en  = 1'b1;
        ack_dly = v.ack_dly;
        wr0     = wr_cnt;
        done0   = done_cnt;
        start_load(v.base, v.len, chk);
        check({p, "_core_rst_rise"}, 32'(core_rst), 32'd1);
        check({p, "_busy_rise"},     32'(busy), 32'd1);
        check({p, "_error_clear"},   32'(error), 32'd0);
        for (int i = 0; i < v.len; i++) begin
            repeat (v.gap) step();
            send_word(base_al + 32'(i * 4), v.words[i]);
        end
        lat = 0;
        while (!done && !error && lat < 300) begin
            step();
            lat++;
        end
        check({p, "_finished"}, 32'(done | error), 32'd1);
        if (v.exp_err) begin
            check({p, "_error"},    32'(error), 32'd1);
            check({p, "_core_rst"}, 32'(core_rst), 32'd1);
            check({p, "_busy"},     32'(busy), 32'd0);
        end else begin
            check({p, "_done"},     32'(done), 32'd1);
            check({p, "_core_rst"}, 32'(core_rst), 32'd0);
            check({p, "_busy"},     32'(busy), 32'd0);
            check({p, "_error"},    32'(error), 32'd0);
            if (v.len == 0) check({p, "_zero_len_latency"}, 32'(lat), 32'd1);
        end
        check({p, "_wr_count"}, 32'(wr_cnt - wr0), 32'(v.len));
        check({p, "_q_empty"},  32'(exp_q.size()), 32'd0);
        step();
        check({p, "_done_pulse"}, 32'(done), 32'd0);
        check({p, "_done_count"}, 32'(done_cnt - done0), v.exp_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        int t, wr0;
        vecs[0] = '{base:32'h0000_0100, len:3, words:{32'h0, 32'h33, 32'h22, 32'h11},
                    ack_dly:0, gap:0, chk:32'h0, chk_given:1'b0, exp_err:1'b0};
        vecs[1] = '{base:32'h0000_0200, len:0, words:{32'h0, 32'h0, 32'h0, 32'h0},
                    ack_dly:0, gap:0, chk:32'h0, chk_given:1'b0, exp_err:1'b0};
        vecs[2] = '{base:32'h0000_0300, len:3, words:{32'h0, 32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001},
                    ack_dly:5, gap:2, chk:32'h0, chk_given:1'b0, exp_err:1'b0};
        vecs[3] = '{base:32'h0000_0403, len:2, words:{32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678},
                    ack_dly:0, gap:1, chk:32'h0, chk_given:1'b0, exp_err:1'b0};
        vecs[4] = '{base:32'hFFFF_FFF8, len:3, words:{32'h0, 32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A},
                    ack_dly:1, gap:0, chk:32'h0, chk_given:1'b0, exp_err:1'b0};
        vecs[5] = '{base:32'h0000_0500, len:1, words:{32'h0, 32'h0, 32'h0, 32'h5555_AAAA},
                    ack_dly:15, gap:0, chk:32'h0, chk_given:1'b0, exp_err:1'b0};
        vecs[6] = '{base:32'h0000_0600, len:2, words:{32'h0, 32'h0, 32'h2, 32'hFFFF_FFFF},
                    ack_dly:0, gap:0, chk:32'h1, chk_given:1'b1, exp_err:1'b0};
        vecs[7] = '{base:32'h0000_0700, len:2, words:{32'h0, 32'h0, 32'h2, 32'hFFFF_FFFF},
                    ack_dly:0, gap:0, chk:32'h2, chk_given:1'b1, exp_err:CHK_ON};

        rst = 1'b1;
        load_start = 1'b0;
        load_base = '0;
        load_len = '0;
        load_chk = '0;
        bus.i_host_valid = 1'b0;
        bus.i_host_data = '0;
        repeat (2) step();
        check_reset("por");
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Withheld acknowledgement: error after WR_TIMEOUT waiting cycles.
        ack_en = 1'b0;
        wr0 = wr_cnt;
        start_load(32'h0000_0800, 2, 32'h0);
        send_word(32'h0000_0800, 32'h0BAD_0001);
        t = 0;
        while (!error && t < 100) begin
            step();
            t++;
        end
        check("tmo_error",    32'(error), 32'd1);
        check("tmo_core_rst", 32'(core_rst), 32'd1);
        check("tmo_busy",     32'(busy), 32'd0);
        check("tmo_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("tmo_latency",  32'(cyc - last_wr_cyc), 32'd17);
        repeat (3) step();
        check("tmo_error_sticky", 32'(error), 32'd1);

        run_vec('{base:32'h0000_0900, len:1, words:{32'h0, 32'h0, 32'h0, 32'h7777_0001},
                  ack_dly:0, gap:0, chk:32'h0, chk_given:1'b0, exp_err:1'b0}, 8);

        // Asynchronous reset after the first of three words.
        ack_en  = 1'b1;
        ack_dly = 0;
        wr0 = wr_cnt;
        start_load(32'h0000_0A00, 3, 32'h0);
        send_word(32'h0000_0A00, 32'h0000_AA01);
        t = 0;
        while (!bus.o_host_ready && t < 50) begin
            step();
            t++;
        end
        check("mid_wr_count", 32'(wr_cnt - wr0), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset("mid_rst");
        step();
        rst = 1'b0;
        bus.i_host_valid = 1'b1;
        bus.i_host_data  = 32'h0000_AA02;
        repeat (20) step();
        bus.i_host_valid = 1'b0;
        check("post_rst_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("post_rst_ready",    32'(bus.o_host_ready), 32'd0);
        check("post_rst_core_rst", 32'(core_rst), 32'd1);
        check("post_rst_busy",     32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=time_expired required=finish");
        $fatal(1, "watchdog");
    end

endmodule
